// File: rtl/ysyx_24080006_sram_axi_slave_pkg.sv
// Shared AXI4-Lite types, response codes and FSM state encodings for the SRAM slave.
package ysyx_24080006_sram_axi_slave_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DELAY = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DELAY = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;

    typedef struct packed {
        logic                  awvalid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic                  wvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
    } axi_w_s2m_t;

    typedef struct packed {
        logic                  arvalid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic                  rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic                  arready;
        logic                  rvalid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
    } axi_r_s2m_t;

    function automatic logic [1:0] axi_resp_of(input logic in_range);
        return in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    endfunction

endpackage

// File: rtl/ysyx_24080006_sram_axi_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h5A; used for response delay
// injection when YSYX_24080006_SRAM_DELAY_EN is defined.
module ysyx_24080006_lfsr8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb  = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
    assign state = r_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= 8'h5A;
        end else if (enable) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

endmodule

// File: rtl/ysyx_24080006_sram_axi_slave.sv
// AXI4-Lite SRAM responder with independent read/write FSMs and byte strobes.
// Define YSYX_24080006_SRAM_DELAY_EN to inject LFSR-driven response delays.
module ysyx_24080006_sram_axi_slave
    import ysyx_24080006_sram_axi_slave_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned DELAY_MAX = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_w_m2s_t w_m2s,
    output axi_w_s2m_t w_s2m,
    input  axi_r_m2s_t r_m2s,
    output axi_r_s2m_t r_s2m
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [31:0] r_mem [DEPTH];

    // Delay source: constant zero unless the LFSR is compiled in
    logic [7:0] w_lfsr;
    logic [7:0] w_delay;
`ifdef YSYX_24080006_SRAM_DELAY_EN
    ysyx_24080006_lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .state  (w_lfsr)
    );
`else
    assign w_lfsr = 8'd0;
`endif
    assign w_delay = 8'(32'(w_lfsr) % (DELAY_MAX + 32'd1));

    // ---------------- write path ----------------
    logic [1:0]  r_wstate, w_wstate_nxt;
    logic        r_aw_got, w_aw_got_nxt;
    logic        r_w_got, w_w_got_nxt;
    logic [31:0] r_awaddr, w_awaddr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_awready, w_awready_nxt;
    logic        r_wready, w_wready_nxt;
    logic        r_bvalid, w_bvalid_nxt;
    logic [1:0]  r_bresp, w_bresp_nxt;
    logic [7:0]  r_wcnt, w_wcnt_nxt;

    logic             w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [31:0]      w_waddr_eff, w_wdata_eff, w_woff;
    logic [3:0]       w_wstrb_eff;
    logic             w_win, w_mem_we;
    logic [IDX_W-1:0] w_widx;

    assign w_aw_hs     = w_m2s.awvalid & r_awready;
    assign w_w_hs      = w_m2s.wvalid & r_wready;
    assign w_aw_have   = r_aw_got | w_aw_hs;
    assign w_w_have    = r_w_got | w_w_hs;
    assign w_waddr_eff = r_aw_got ? r_awaddr : w_m2s.awaddr;
    assign w_wdata_eff = r_w_got ? r_wdata : w_m2s.wdata;
    assign w_wstrb_eff = r_w_got ? r_wstrb : w_m2s.wstrb;
    assign w_woff      = w_waddr_eff - BASE;
    assign w_win       = {1'b0, w_woff} < SPAN;
    assign w_widx      = w_woff[IDX_W+1:2];

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_got_nxt  = r_aw_got;
        w_w_got_nxt   = r_w_got;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_wcnt_nxt    = r_wcnt;
        w_mem_we      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_awaddr_nxt = w_m2s.awaddr;
                if (w_w_hs) begin
                    w_wdata_nxt = w_m2s.wdata;
                    w_wstrb_nxt = w_m2s.wstrb;
                end
                if (w_aw_have && w_w_have) begin
                    w_mem_we      = w_win;
                    w_bresp_nxt   = axi_resp_of(w_win);
                    w_aw_got_nxt  = 1'b0;
                    w_w_got_nxt   = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    if (w_delay == 8'd0) begin
                        w_wstate_nxt = W_RESP;
                        w_bvalid_nxt = 1'b1;
                    end else begin
                        w_wstate_nxt = W_DELAY;
                        w_wcnt_nxt   = w_delay;
                    end
                end else begin
                    w_aw_got_nxt  = w_aw_have;
                    w_w_got_nxt   = w_w_have;
                    w_awready_nxt = ~w_aw_have;
                    w_wready_nxt  = ~w_w_have;
                end
            end
            W_DELAY: begin
                if (r_wcnt <= 8'd1) begin
                    w_wstate_nxt = W_RESP;
                    w_bvalid_nxt = 1'b1;
                    w_wcnt_nxt   = 8'd0;
                end else begin
                    w_wcnt_nxt = r_wcnt - 8'd1;
                end
            end
            W_RESP: begin
                if (w_m2s.bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: begin
                w_wstate_nxt  = W_IDLE;
                w_bvalid_nxt  = 1'b0;
                w_awready_nxt = 1'b0;
                w_wready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wstate  <= W_IDLE;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_wcnt    <= 8'd0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_got  <= w_aw_got_nxt;
            r_w_got   <= w_w_got_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_wcnt    <= w_wcnt_nxt;
        end
    end

    // Array is not reset; strobed bytes commit on the edge completing AW+W
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb_eff[i]) r_mem[w_widx][8*i +: 8] <= w_wdata_eff[8*i +: 8];
            end
        end
    end

    assign w_s2m.awready = r_awready;
    assign w_s2m.wready  = r_wready;
    assign w_s2m.bvalid  = r_bvalid;
    assign w_s2m.bresp   = r_bresp;

    // ---------------- read path ----------------
    logic [1:0]  r_rstate, w_rstate_nxt;
    logic        r_arready, w_arready_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic [1:0]  r_rresp, w_rresp_nxt;
    logic [7:0]  r_rcnt, w_rcnt_nxt;

    logic             w_ar_hs, w_rin;
    logic [31:0]      w_roff;
    logic [IDX_W-1:0] w_ridx;

    assign w_ar_hs = r_m2s.arvalid & r_arready;
    assign w_roff  = r_m2s.araddr - BASE;
    assign w_rin   = {1'b0, w_roff} < SPAN;
    assign w_ridx  = w_roff[IDX_W+1:2];

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        w_rcnt_nxt    = r_rcnt;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    w_rdata_nxt   = w_rin ? r_mem[w_ridx] : 32'd0;
                    w_rresp_nxt   = axi_resp_of(w_rin);
                    if (w_delay == 8'd0) begin
                        w_rstate_nxt = R_RESP;
                        w_rvalid_nxt = 1'b1;
                    end else begin
                        w_rstate_nxt = R_DELAY;
                        w_rcnt_nxt   = w_delay;
                    end
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DELAY: begin
                if (r_rcnt <= 8'd1) begin
                    w_rstate_nxt = R_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_rcnt_nxt   = 8'd0;
                end else begin
                    w_rcnt_nxt = r_rcnt - 8'd1;
                end
            end
            R_RESP: begin
                if (r_m2s.rready) begin
                    w_rstate_nxt  = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: begin
                w_rstate_nxt  = R_IDLE;
                w_rvalid_nxt  = 1'b0;
                w_arready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= 2'b00;
            r_rcnt    <= 8'd0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rcnt    <= w_rcnt_nxt;
        end
    end

    assign r_s2m.arready = r_arready;
    assign r_s2m.rvalid  = r_rvalid;
    assign r_s2m.rdata   = r_rdata;
    assign r_s2m.rresp   = r_rresp;

endmodule
